// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder: multi-cycle search for a {rot, imm8} operand2 encoding of a 32-bit constant.
// Optional inverted (MVN/BIC) search is compiled in with `define IMM_ENC_INVERT_EN.
`default_nettype none

module imm_operand_encoder #(
  parameter int ROT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shift_operand,
  output logic        inverted
);

  localparam logic [4:0] STEP = 5'(ROT_PER_CYCLE);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [31:0] val;
  logic [4:0]  rot_base;

  logic        hit;
  logic        hit_inv;
  logic [3:0]  hit_rot;
  logic [7:0]  hit_imm;
  logic        last_cycle;

  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [63:0] t;
    t = {v, v} << {r, 1'b0};
    return t[63:32];
  endfunction

  assign last_cycle = ((rot_base + STEP) == 5'd16);

  // Walk rotations from highest to lowest so the lowest matching one overwrites the rest.
  always_comb begin
    logic [3:0]  rot;
    logic [31:0] cand;
    logic [31:0] cand_n;
    hit     = 1'b0;
    hit_inv = 1'b0;
    hit_rot = 4'd0;
    hit_imm = 8'd0;
    rot     = 4'd0;
    cand    = 32'd0;
    cand_n  = 32'd0;
    for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
      rot    = rot_base[3:0] + 4'(i);
      cand   = rol2(val, rot);
      cand_n = rol2(~val, rot);
      if (cand[31:8] == 24'd0) begin
        hit     = 1'b1;
        hit_inv = 1'b0;
        hit_rot = rot;
        hit_imm = cand[7:0];
      end
`ifdef IMM_ENC_INVERT_EN
      else if (cand_n[31:8] == 24'd0) begin
        hit     = 1'b1;
        hit_inv = 1'b1;
        hit_rot = rot;
        hit_imm = cand_n[7:0];
      end
`endif
    end
  end

`ifdef IMM_ENC_INVERT_EN
  logic inv_q;
  assign inverted = inv_q;
`else
  logic unused_inv;
  assign unused_inv = hit_inv;
  assign inverted   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      val           <= 32'd0;
      rot_base      <= 5'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      shift_operand <= 12'd0;
`ifdef IMM_ENC_INVERT_EN
      inv_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            val           <= value;
            rot_base      <= 5'd0;
            found         <= 1'b0;
            shift_operand <= 12'd0;
`ifdef IMM_ENC_INVERT_EN
            inv_q         <= 1'b0;
`endif
            busy          <= 1'b1;
            state         <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            found         <= 1'b1;
            shift_operand <= {hit_rot, hit_imm};
`ifdef IMM_ENC_INVERT_EN
            inv_q         <= hit_inv;
`endif
            done          <= 1'b1;
            state         <= DONE;
          end else if (last_cycle) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rot_base <= rot_base + STEP;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_operand_encoder.sv
// Testbench for imm_operand_encoder: one instance searching 1 rotation/cycle, one searching 4.
`default_nettype none

module tb_imm_operand_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;

  logic        busy1, done1, found1, inv1;
  logic [11:0] so1;
  logic        busy4, done4, found4, inv4;
  logic [11:0] so4;

  int checks = 0;
  int errors = 0;

  imm_operand_encoder #(.ROT_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy1), .done(done1), .found(found1), .shift_operand(so1), .inverted(inv1)
  );

  imm_operand_encoder #(.ROT_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy4), .done(done4), .found(found4), .shift_operand(so4), .inverted(inv4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic        f;
    logic [11:0] so;
    logic        inv;
    int          lat1;
    int          lat4;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edge 1 is the accepting edge; lat is the edge number after which done is first seen.
  task automatic apply(input logic [31:0] v, input bit mid_start,
                       output int lat1, output int lat4, output int n1, output int n4);
    int e;
    lat1 = 0; lat4 = 0; n1 = 0; n4 = 0;
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = $urandom;
    e = 1;
    check("busy1_after_accept", 32'(busy1), 32'd1);
    while ((lat1 == 0 || lat4 == 0) && e < 40) begin
      @(posedge clk);
      e++;
      #1;
      if (done1) begin n1++; if (lat1 == 0) lat1 = e; end
      if (done4) begin n4++; if (lat4 == 0) lat4 = e; end
      if (mid_start) start = (e == 4 || e == 5);
    end
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done1) n1++;
      if (done4) n4++;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int l1, l4, c1, c4;
    vecs[0] = '{32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 2, 2};
    vecs[1] = '{32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 6, 3};
    vecs[2] = '{32'h0000_0104, 1'b1, 12'hF41, 1'b0, 17, 5};
    vecs[3] = '{32'h0000_0101, 1'b0, 12'h000, 1'b0, 17, 5};
    vecs[4] = '{32'h0000_0000, 1'b1, 12'h000, 1'b0, 2, 2};
    vecs[5] = '{32'h0000_03FC, 1'b1, 12'hFFF, 1'b0, 17, 5};
    vecs[6] = '{32'hF000_000F, 1'b1, 12'h2FF, 1'b0, 4, 2};
    vecs[7] = '{32'h00AB_0000, 1'b1, 12'h8AB, 1'b0, 10, 4};
`ifdef IMM_ENC_INVERT_EN
    vecs[8] = '{32'hFFFF_FF00, 1'b1, 12'h0FF, 1'b1, 2, 2};
`else
    vecs[8] = '{32'hFFFF_FF00, 1'b0, 12'h000, 1'b0, 17, 5};
`endif

    rst_n = 1'b0;
    start = 1'b0;
    value = 32'd0;
    #12;
    check("reset_busy",  32'(busy1), 32'd0);
    check("reset_done",  32'(done1), 32'd0);
    check("reset_found", 32'(found1), 32'd0);
    check("reset_so",    32'(so1), 32'd0);
    check("reset_inv",   32'(inv1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].v, 1'b0, l1, l4, c1, c4);
      check($sformatf("lat1[%0d]", i),   32'(l1), 32'(vecs[i].lat1));
      check($sformatf("lat4[%0d]", i),   32'(l4), 32'(vecs[i].lat4));
      check($sformatf("ndone1[%0d]", i), 32'(c1), 32'd1);
      check($sformatf("ndone4[%0d]", i), 32'(c4), 32'd1);
      check($sformatf("found1[%0d]", i), 32'(found1), 32'(vecs[i].f));
      check($sformatf("so1[%0d]", i),    32'(so1), 32'(vecs[i].so));
      check($sformatf("inv1[%0d]", i),   32'(inv1), 32'(vecs[i].inv));
      check($sformatf("found4[%0d]", i), 32'(found4), 32'(vecs[i].f));
      check($sformatf("so4[%0d]", i),    32'(so4), 32'(vecs[i].so));
      check($sformatf("inv4[%0d]", i),   32'(inv4), 32'(vecs[i].inv));
      check($sformatf("idle1[%0d]", i),  32'(busy1), 32'd0);
    end

    // start re-asserted while busy must be ignored
    apply(32'h0000_0101, 1'b1, l1, l4, c1, c4);
    check("mid_start_lat1",   32'(l1), 32'd17);
    check("mid_start_lat4",   32'(l4), 32'd5);
    check("mid_start_ndone1", 32'(c1), 32'd1);
    check("mid_start_ndone4", 32'(c4), 32'd1);
    check("mid_start_busy4",  32'(busy4), 32'd0);

    // Asynchronous reset in the middle of a search
    @(negedge clk);
    value = 32'h0000_0104;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(busy1), 32'd0);
    check("midrst_found", 32'(found1), 32'd0);
    check("midrst_so",    32'(so1), 32'd0);
    check("midrst_done",  32'(done1), 32'd0);
    c1 = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done1) c1++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done1) c1++;
    end
    check("midrst_no_done", 32'(c1), 32'd0);
    apply(32'h0000_0000, 1'b0, l1, l4, c1, c4);
    check("postrst_lat1",  32'(l1), 32'd2);
    check("postrst_found", 32'(found1), 32'd1);
    check("postrst_so",    32'(so1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_operand_encoder.md
Name: imm_operand_encoder

Overview:
- Multi-cycle inverse of the data-processing operand2 immediate decode, where value = ROR(imm8, 2*rot).
- Given a 32-bit constant, searches the 16 rotations for a 12-bit shift_operand {rot[3:0], imm8[7:0]} that reproduces it.
- Used by the instruction-build / self-test path to generate immediate-form data-processing instructions feeding the execute stage's operand2 path.

Parameters:
- ROT_PER_CYCLE, 1, rotations tested per SEARCH cycle; legal values 1, 2, 4, 8, 16; SEARCH_CYCLES = 16/ROT_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; accepted only when busy=0
- value  input  32  constant to encode; sampled on the accepting edge
- busy  output  1  high while state is SEARCH or DONE
- done  output  1  one-cycle result-valid pulse
- found  output  1  1 = encodable, valid while/after done
- shift_operand  output  12  {rot, imm8}; 12'h000 when not found
- inverted  output  1  1 = encoding is of ~value (MVN/BIC form); constant 0 when the feature is compiled out

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, found=0, shift_operand=0, inverted=0, internal value/rotation counter cleared. Applies immediately mid-search; a pending search is discarded, no done is issued.
- States: IDLE, SEARCH, DONE.
- IDLE: on clk edge with start=1, latch value, clear rotation counter r, clear found/inverted/shift_operand, go to SEARCH. start=0: stay.
- SEARCH cycle k (0-based) tests rotations r = k*ROT_PER_CYCLE .. k*ROT_PER_CYCLE+ROT_PER_CYCLE-1.
  - For each r: cand = ROL(value, 2r), 32-bit rotate. Match iff cand[31:8]==0.
  - Lowest matching r wins, both within a cycle and across cycles.
  - Match: register found=1, shift_operand={r[3:0], cand[7:0]}, go to DONE.
  - No match and k = SEARCH_CYCLES-1: found=0, shift_operand=0, go to DONE.
  - Otherwise advance k.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency: done is high in the cycle following the (k+1)-th edge after the accepting edge, where k is the matching SEARCH cycle. Worst case is SEARCH_CYCLES+1 edges from acceptance.
- value=0 matches at r=0: shift_operand=0x000, found=1.
- start while busy=1 (including during DONE) is ignored; no queuing. A start in the cycle after DONE is accepted normally.
- found, shift_operand and inverted hold after done until the next accepted start clears them.
- The value input may change freely after acceptance; only the latched copy is used.

Optional Feature:
- Macro IMM_ENC_INVERT_EN.
- Defined: each tested rotation also checks ~value using the same rule.
- Per rotation, the plain match has priority over the inverted match. Across rotations, the lowest r with either match wins.
- On an inverted win: inverted=1, shift_operand={r, ROL(~value,2r)[7:0]}.
- Undefined: no inverted datapath; inverted tied 0; behaviour identical to plain search.

Test Plan:
- ROT_PER_CYCLE=1, value=0x000000FF, start pulse -> done 2 edges after acceptance; found=1, shift_operand=0x0FF, inverted=0.
- ROT_PER_CYCLE=1, value=0xFF000000 -> rot=4, done at edge 6; shift_operand=0x4FF, found=1.
- ROT_PER_CYCLE=1, value=0x00000104 -> shift_operand=0xF41 (rot=15, imm8=0x41), done at edge 17. Repeat with ROT_PER_CYCLE=4 -> same result, done at edge 5.
- value=0x00000101 (9-bit span) -> found=0, shift_operand=0x000, done at SEARCH_CYCLES+1. start re-asserted mid-search -> ignored, single done observed.
- value=0xFFFFFF00: with IMM_ENC_INVERT_EN -> found=1, inverted=1, shift_operand=0x0FF. Without the macro -> found=0, inverted=0.
- Start value=0x00000104 with ROT_PER_CYCLE=1, drop rst_n low after 5 edges -> all outputs 0 immediately, no done. After release, start value=0 -> found=1, shift_operand=0x000, done at edge 2.
